// File: rtl/wb_pipe_stage.sv
// Writeback stage: picks ALU / load / link / CSR result, extends sub-word loads, registers the RF write.
// Latency: 1 cycle from accepted input to rf_* outputs; retired_count updates on the same edge.
// Backpressure: in_ready = ~hold; hold freezes all state, flush kills both the incoming and held op.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     MEM-stage handshake (transfer on in_valid & in_ready)
//   hold, flush             freeze stage / kill incoming and held instruction
//   alu_data, memory_data,
//   pc_plus4, csr_data      candidate result sources, chosen by wb_sel
//   load_size, load_unsigned,
//   addr_lo                 sub-word load extraction controls (used only when wb_sel = 01)
//   rd_addr, reg_write      destination register and its write flag
//   rf_we, rf_waddr,
//   rf_wdata                registered register-file write port
//   retired_count           wrapping count of accepted instructions
module wb_pipe_stage #(
   parameter int WORD_SIZE = 32,
   parameter int NUM_REGS  = 32,
   parameter int REG_SEL   = $clog2(NUM_REGS),
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 hold,
   input  logic                 flush,
   input  logic [WORD_SIZE-1:0] alu_data,
   input  logic [WORD_SIZE-1:0] memory_data,
   input  logic [WORD_SIZE-1:0] pc_plus4,
   input  logic [WORD_SIZE-1:0] csr_data,
   input  logic [1:0]           wb_sel,
   input  logic [1:0]           load_size,
   input  logic                 load_unsigned,
   input  logic [1:0]           addr_lo,
   input  logic [REG_SEL-1:0]   rd_addr,
   input  logic                 reg_write,
   output logic                 rf_we,
   output logic [REG_SEL-1:0]   rf_waddr,
   output logic [WORD_SIZE-1:0] rf_wdata,
   output logic [CNT_WIDTH-1:0] retired_count
);

   logic                 r_valid;
   logic                 r_reg_write;
   logic [REG_SEL-1:0]   r_waddr;
   logic [WORD_SIZE-1:0] r_wdata;
   logic [CNT_WIDTH-1:0] r_count;

   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic                 w_byte_fill;
   logic                 w_half_fill;
   logic [WORD_SIZE-1:0] w_load;
   logic [WORD_SIZE-1:0] w_result;

   assign in_ready = ~hold;

   // Lane selection from the aligned word; halfword ignores addr_lo[0]
   // because misaligned accesses are trapped upstream, not here.
   assign w_byte = memory_data[{addr_lo, 3'b000} +: 8];
   assign w_half = memory_data[{addr_lo[1], 4'b0000} +: 16];

   // Fill bit is the lane's MSB for signed loads, zero for unsigned ones.
   assign w_byte_fill = ~load_unsigned & w_byte[7];
   assign w_half_fill = ~load_unsigned & w_half[15];

   always_comb begin
      w_load = memory_data;
      case (load_size)
         2'b00:   w_load = {{(WORD_SIZE-8){w_byte_fill}}, w_byte};
         2'b01:   w_load = {{(WORD_SIZE-16){w_half_fill}}, w_half};
         default: w_load = memory_data;
      endcase
   end

   always_comb begin
      w_result = alu_data;
      case (wb_sel)
         2'b00:   w_result = alu_data;
         2'b01:   w_result = w_load;
         2'b10:   w_result = pc_plus4;
         default: w_result = csr_data;
      endcase
   end

   // Priority: reset > flush > hold > transfer > bubble.
   // On flush/bubble only the valid bit drops; data and address keep
   // stale contents since rf_we gates them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_count     <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (!hold) begin
         if (in_valid) begin
            r_valid     <= 1'b1;
            r_reg_write <= reg_write;
            r_waddr     <= rd_addr;
            r_wdata     <= w_result;
            r_count     <= r_count + CNT_WIDTH'(1);
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   // Decoded purely from registered state, so rf_we has no input-to-output path.
   // x0 is hardwired to zero and must never be written.
   assign rf_we         = r_valid & r_reg_write & (r_waddr != '0);
   assign rf_waddr      = r_waddr;
   assign rf_wdata      = r_wdata;
   assign retired_count = r_count;

endmodule

// File: tb/tb_wb_pipe_stage.sv
module tb_wb_pipe_stage;

   localparam int WS = 32;
   localparam int RS = 5;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          hold;
   logic          flush;
   logic [WS-1:0] alu_data;
   logic [WS-1:0] memory_data;
   logic [WS-1:0] pc_plus4;
   logic [WS-1:0] csr_data;
   logic [1:0]    wb_sel;
   logic [1:0]    load_size;
   logic          load_unsigned;
   logic [1:0]    addr_lo;
   logic [RS-1:0] rd_addr;
   logic          reg_write;
   logic          rf_we;
   logic [RS-1:0] rf_waddr;
   logic [WS-1:0] rf_wdata;
   logic [CW-1:0] retired_count;

   wb_pipe_stage #(.WORD_SIZE(WS), .NUM_REGS(32), .REG_SEL(RS), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .hold(hold), .flush(flush), .alu_data(alu_data), .memory_data(memory_data),
      .pc_plus4(pc_plus4), .csr_data(csr_data), .wb_sel(wb_sel), .load_size(load_size),
      .load_unsigned(load_unsigned), .addr_lo(addr_lo), .rd_addr(rd_addr),
      .reg_write(reg_write), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .retired_count(retired_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   bit          m_init = 1'b0;
   bit          m_we;
   bit          m_chk;     // address/data are defined (after reset or a capture)
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_cnt;

   function automatic logic [31:0] expect_data(
      input logic [1:0] sel, input logic [1:0] ls, input logic lu, input logic [1:0] al,
      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
      input logic [31:0] csr);
      int unsigned v;
      if (sel == 2'd0) return alu;
      if (sel == 2'd2) return pc;
      if (sel == 2'd3) return csr;
      if (ls >= 2'd2) return mem;
      if (ls == 2'd0) begin
         v = (mem >> (8 * int'(al))) & 32'hFF;
         if (!lu && v >= 128) v = v + 32'hFFFF_FF00;
      end else begin
         v = (mem >> (16 * int'(al[1]))) & 32'hFFFF;
         if (!lu && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_init = 1'b1; m_we = 1'b0; m_chk = 1'b1;
         m_addr = '0; m_data = '0; m_cnt = 0;
      end else if (flush) begin
         m_we = 1'b0; m_chk = 1'b0;
      end else if (hold) begin
         m_we = m_we;
      end else if (in_valid) begin
         m_we   = reg_write && (rd_addr != 0);
         m_addr = rd_addr;
         m_data = expect_data(wb_sel, load_size, load_unsigned, addr_lo,
                              alu_data, memory_data, pc_plus4, csr_data);
         m_cnt  = (m_cnt + 1) % 16;
         m_chk  = 1'b1;
      end else begin
         m_we = 1'b0; m_chk = 1'b0;
      end
   end

   // ---------------- literal pins (written by stimulus, checked by compare) ----------------
   int          lit_seq = 0;
   int          lit_seen = 0;
   bit          lit_we;
   int          lit_cnt;
   bit          lit_dchk;
   logic [4:0]  lit_addr;
   logic [31:0] lit_data;

   // ---------------- compare process ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_init) begin
         chk("in_ready", 32'(in_ready), 32'(!hold));
         chk("rf_we", 32'(rf_we), 32'(m_we));
         chk("retired_count", 32'(retired_count), 32'(m_cnt));
         if (m_chk) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
            chk("rf_wdata", rf_wdata, m_data);
         end
         if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            chk("lit_rf_we", 32'(rf_we), 32'(lit_we));
            chk("lit_count", 32'(retired_count), 32'(lit_cnt));
            chk("model_count", 32'(m_cnt), 32'(lit_cnt));
            if (lit_dchk) begin
               chk("lit_rf_waddr", 32'(rf_waddr), 32'(lit_addr));
               chk("lit_rf_wdata", rf_wdata, lit_data);
               chk("model_data", m_data, lit_data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic pin(input bit we, input int cnt, input bit dchk,
                      input logic [4:0] a, input logic [31:0] d);
      lit_we = we; lit_cnt = cnt; lit_dchk = dchk; lit_addr = a; lit_data = d;
      lit_seq++;
   endtask

   task automatic rand_in();
      in_valid      = 1'b1;
      hold          = 1'b0;
      flush         = 1'b0;
      alu_data      = $urandom;
      memory_data   = $urandom;
      pc_plus4      = $urandom;
      csr_data      = $urandom;
      wb_sel        = 2'($urandom_range(0, 3));
      load_size     = 2'($urandom_range(0, 3));
      load_unsigned = 1'($urandom_range(0, 1));
      addr_lo       = 2'($urandom_range(0, 3));
      rd_addr       = 5'($urandom_range(0, 31));
      reg_write     = 1'($urandom_range(0, 1));
   endtask

   initial begin
      rst_n = 1'b0;
      rand_in();
      hold = 1'($urandom_range(0, 1));
      cyc();
      rand_in();
      hold = 1'($urandom_range(0, 1));
      cyc();
      pin(0, 0, 1, 5'd0, 32'h0);
      rst_n = 1'b1;

      // source select
      rand_in(); wb_sel = 2'b00; alu_data = 32'h0000_1234; rd_addr = 5'd5; reg_write = 1'b1;
      cyc(); pin(1, 1, 1, 5'd5, 32'h0000_1234);
      rand_in(); wb_sel = 2'b10; pc_plus4 = 32'h8000_0004; rd_addr = 5'd6; reg_write = 1'b1;
      cyc(); pin(1, 2, 1, 5'd6, 32'h8000_0004);
      rand_in(); wb_sel = 2'b11; csr_data = 32'hDEAD_BEEF; rd_addr = 5'd8; reg_write = 1'b1;
      cyc(); pin(1, 3, 1, 5'd8, 32'hDEAD_BEEF);

      // load extraction
      rand_in(); wb_sel = 2'b01; memory_data = 32'h80F1_7F82; rd_addr = 5'd9; reg_write = 1'b1;
      load_size = 2'b00; addr_lo = 2'd0; load_unsigned = 1'b0;
      cyc(); pin(1, 4, 1, 5'd9, 32'hFFFF_FF82);
      load_size = 2'b00; addr_lo = 2'd1; load_unsigned = 1'b1;
      cyc(); pin(1, 5, 1, 5'd9, 32'h0000_007F);
      load_size = 2'b01; addr_lo = 2'd2; load_unsigned = 1'b0;
      cyc(); pin(1, 6, 1, 5'd9, 32'hFFFF_80F1);
      load_size = 2'b01; addr_lo = 2'd3; load_unsigned = 1'b1;
      cyc(); pin(1, 7, 1, 5'd9, 32'h0000_80F1);
      load_size = 2'b10; addr_lo = 2'd3; load_unsigned = 1'b0;
      cyc(); pin(1, 8, 1, 5'd9, 32'h80F1_7F82);

      // x0 suppression and reg_write = 0
      rand_in(); rd_addr = 5'd0; reg_write = 1'b1;
      cyc(); pin(0, 9, 0, 5'd0, 32'h0);
      rand_in(); rd_addr = 5'd7; reg_write = 1'b0;
      cyc(); pin(0, 10, 0, 5'd0, 32'h0);

      // hold / flush
      rand_in(); wb_sel = 2'b00; alu_data = 32'hAAAA_5555; rd_addr = 5'd3; reg_write = 1'b1;
      cyc(); pin(1, 11, 1, 5'd3, 32'hAAAA_5555);
      for (int i = 0; i < 3; i++) begin
         rand_in(); hold = 1'b1; reg_write = 1'b1; rd_addr = 5'd12;
         cyc(); pin(1, 11, 1, 5'd3, 32'hAAAA_5555);
      end
      rand_in(); hold = 1'b1; flush = 1'b1;
      cyc(); pin(0, 11, 0, 5'd0, 32'h0);
      rand_in(); flush = 1'b1; reg_write = 1'b1; rd_addr = 5'd4;
      cyc(); pin(0, 11, 0, 5'd0, 32'h0);
      rand_in(); in_valid = 1'b0;
      cyc(); pin(0, 11, 0, 5'd0, 32'h0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rand_in();
         rst_n    = ($urandom_range(0, 49) != 0);
         in_valid = ($urandom_range(0, 9) < 7);
         hold     = ($urandom_range(0, 9) < 3);
         flush    = ($urandom_range(0, 9) < 1);
         cyc();
      end

      // counter wrap
      rst_n = 1'b0; rand_in();
      cyc();
      rst_n = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         rand_in(); rd_addr = 5'd1; reg_write = 1'b1;
         cyc();
         if (i == 15) pin(1, 15, 0, 5'd0, 32'h0);
         if (i == 16) pin(1, 0, 0, 5'd0, 32'h0);
         if (i == 17) pin(1, 1, 0, 5'd0, 32'h0);
      end
      rand_in(); rst_n = 1'b0;
      cyc(); pin(0, 0, 1, 5'd0, 32'h0);
      rst_n = 1'b1; rand_in(); in_valid = 1'b0;
      cyc();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
Registered, parametrised writeback stage sitting between the MEM stage and the register file write port.
- Selects one of four result sources: ALU, load data, PC+4 link, CSR read.
- Extracts and sign/zero-extends sub-word loads from the aligned memory word.
- Registers the write request once with valid/hold control.
- Keeps a retired-instruction counter.

Parameters:
WORD_SIZE, 32, data path width in bits (must be a multiple of 16)
NUM_REGS, 32, architectural register count
REG_SEL, $clog2(NUM_REGS), register index width
CNT_WIDTH, 32, retired-instruction counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  MEM stage presents a valid instruction
in_ready  out  1  stage accepts input this cycle
hold  in  1  freeze stage contents (register file port busy)
flush  in  1  kill the incoming instruction and the held instruction
alu_data  in  WORD_SIZE  ALU result
memory_data  in  WORD_SIZE  aligned memory read word
pc_plus4  in  WORD_SIZE  link value
csr_data  in  WORD_SIZE  CSR read value
wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 CSR
load_size  in  2  00 byte, 01 half, 10/11 word
load_unsigned  in  1  1 = zero-extend, 0 = sign-extend
addr_lo  in  2  byte offset of the load address
rd_addr  in  REG_SEL  destination register
reg_write  in  1  instruction writes rd
rf_we  out  1  register file write enable
rf_waddr  out  REG_SEL  register file write index
rf_wdata  out  WORD_SIZE  register file write data
retired_count  out  CNT_WIDTH  count of valid instructions committed

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low. All registers update on the rising edge of `clk`.
- Reset (rst_n = 0 at a clock edge): rf_we = 0, rf_waddr = 0, rf_wdata = 0, retired_count = 0, internal valid = 0.
- in_ready = ~hold (combinational). A transfer occurs when in_valid & in_ready.
- Latency: exactly 1 cycle. Data accepted at edge N appears on rf_* after edge N and is valid for the following cycle.
- Load extraction for wb_sel = 01:
  - Byte: lane addr_lo selects bits [8*addr_lo+7 : 8*addr_lo].
  - Half: addr_lo[1] selects the low or high 16 bits; addr_lo[0] is ignored (no misalign trap here).
  - Word: addr_lo is ignored.
  - Extension fills up to WORD_SIZE with the sign bit, or with zeros when load_unsigned = 1.
- For wb_sel other than 01, load_size, load_unsigned and addr_lo are ignored.
- rf_we = internal valid & registered reg_write & (registered rd_addr != 0). Register x0 is never written.
- Per-edge update priority:
  1. rst_n = 0: reset.
  2. flush = 1: internal valid <= 0, rf_we <= 0; data/address registers may hold stale values; the counter does not increment.
  3. hold = 1: all registers retain their values and the counter does not increment. A held write stays asserted on rf_we, and the register file must tolerate a repeated identical write.
  4. Transfer: capture the selected/extended data, rd_addr and reg_write; internal valid <= 1.
  5. No transfer (in_valid = 0, hold = 0): internal valid <= 0, rf_we <= 0.
- retired_count increments by 1 on each edge where a transfer is captured (step 4), whether or not reg_write = 1. It wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Simultaneous events: flush with hold gives flush; flush with in_valid drops the input and does not count it; reset mid-hold clears everything.
- Output registers drive rf_* directly, with no combinational path from inputs to rf_*.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with random inputs -> rf_we = 0, rf_wdata = 0, retired_count = 0; in_ready follows ~hold.
- Source select: alu_data = 0x0000_1234, rd = 5, wb_sel = 00, in_valid = 1 -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x0000_1234, count = 1. Repeat with wb_sel = 10, pc_plus4 = 0x8000_0004 -> 0x8000_0004. Repeat with wb_sel = 11, csr_data = 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Load extraction: memory_data = 0x80F1_7F82:
  - byte, addr_lo = 0, signed -> 0xFFFF_FF82
  - byte, addr_lo = 1, unsigned -> 0x0000_007F
  - half, addr_lo = 2, signed -> 0xFFFF_80F1
  - half, addr_lo = 2, unsigned -> 0x0000_80F1
  - word -> 0x80F1_7F82
- x0 suppression: rd = 0, reg_write = 1, valid -> rf_we = 0 while count still increments. Also reg_write = 0, rd = 7 -> rf_we = 0 and count increments.
- Hold/flush: accept a write to rd = 3, then hold 3 cycles with new in_valid data -> rf_* unchanged, in_ready = 0, count unchanged. Then assert flush and hold together -> next cycle rf_we = 0, count unchanged. Then flush with in_valid -> rf_we = 0.
- Counter wrap: with CNT_WIDTH = 4, apply 17 back-to-back valid transfers -> retired_count goes 15 -> 0 -> 1; apply rst_n = 0 mid-stream -> 0 on the next edge.
